cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Sequencing FSM for the 8-bit accumulator CPU. It sits between the instruction register and the datapath.
- Consumes the 3-bit opcode from the instruction register and the `zero` flag produced by the ALU.
- Drives every datapath strobe: address mux select, memory read/write, IR/PC/ACC loads, PC increment, data bus enable.
- Every instruction takes a fixed 8-phase cycle.

Parameters:
- OP_HLT, 3'b000, halt opcode
- OP_SKZ, 3'b001, skip next instruction if zero
- OP_ADD, 3'b010, ACC <= ACC + mem
- OP_AND, 3'b011, ACC <= ACC & mem
- OP_XOR, 3'b100, ACC <= ACC ^ mem
- OP_LDA, 3'b101, ACC <= mem
- OP_STO, 3'b110, mem <= ACC
- OP_JMP, 3'b111, PC <= operand address

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  3  current IR opcode field
- zero  in  1  ALU zero flag (ALU out == 0)
- sel  out  1  address mux: 1 = PC, 0 = IR operand field
- rd  out  1  memory read enable
- wr  out  1  memory write enable
- ld_ir  out  1  load instruction register
- inc_pc  out  1  increment program counter
- ld_pc  out  1  load PC from IR operand field
- ld_ac  out  1  load accumulator from ALU out
- data_e  out  1  drive ALU out onto data bus
- halt  out  1  CPU halted
- phase  out  3  current phase (debug)

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge of `clk`.
- State register: 3-bit phase counter plus a 1-bit halted flag.
- Reset: phase = 0, halted = 0. All strobes are 0 except sel = 1 (phase-0 decode).
- Phase sequencing: while not halted, phase advances 0→1→…→7→0 every clk. 7 wraps to 0 with no idle gap.
- Output decode: outputs are combinational decode of (phase, opcode, zero, halted) with no extra register. ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
  - phase 0 INST_ADDR: sel=1
  - phase 1 INST_FETCH: sel=1, rd=1
  - phase 2 INST_LOAD: sel=1, rd=1, ld_ir=1
  - phase 3 IDLE: sel=1, rd=1, ld_ir=1
  - phase 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT
  - phase 5 OP_FETCH: rd=ALUOP
  - phase 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO)
  - phase 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); inc_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO)
- Halt entry: if opcode==HLT at phase 4, halted is set on that edge. The phase then freezes at 4.
- While halted: halt=1, all other strobes 0, no memory access. The halted condition overrides the phase decode.
- Halt exit: only rst clears halted (see Optional Feature).
- Zero sampling: `zero` is used only in phase 6 and only for SKZ. It is ignored at every other phase. Glitches on it outside phase 6 have no effect.
- Write/read exclusivity: wr and rd are never both 1 in any cycle. An implementation assertion must check this.
- Opcode timing: opcode is only meaningful from phase 4 onward, since the IR loads at phases 2–3. Outputs at phases 0–3 are opcode-independent.
- Reset mid-instruction: rst at any phase, halted or not, returns to phase 0 next edge with all strobes at reset values. No partial write: wr is 0 in the reset cycle.
- Unknown/X opcode: treated as no ALUOP, no JMP/STO/SKZ/HLT. The phases still advance.

Optional Feature:
- Macro: CTRL_HALT_RESUME_EN.
- Defined: adds input port `resume` (1 bit). When halted and resume==1 at a rising edge (and rst==0), halted clears and phase goes to 5. The instruction completes as a no-op, so the next fetch is at PC+1. resume is ignored when not halted. rst takes priority over resume.
- Undefined: no `resume` port; halt exits only on rst.

Test Plan:
- Reset: hold rst=1 for 2 clks, release → phase=0, sel=1, rd=wr=ld_ir=inc_pc=ld_pc=ld_ac=data_e=halt=0. The next 8 edges give phase 1..7,0.
- ADD (opcode=3'b010), zero=0 → rd=1 at phases 1,2,3,5,6,7; ld_ir=1 at phases 2,3; inc_pc=1 only at phase 4; ld_ac=1 only at phase 7; wr=0 throughout.
- STO (opcode=3'b110) → data_e=1 at phases 6,7; wr=1 only at phase 7; rd=0 at phases 5–7; ld_ac=0.
- SKZ (opcode=3'b001): with zero=1, inc_pc=1 at phases 4 and 6 (two increments). With zero=0, inc_pc=1 at phase 4 only. Toggling zero at phase 5 has no effect.
- JMP (opcode=3'b111) → ld_pc=1 at phases 6,7; inc_pc=1 at phases 4,7.
- HLT (opcode=3'b000) → halt=1 from phase 4, phase stays 4 for 20 clks with all other strobes 0. rst=1 then gives phase=0, halt=0. With CTRL_HALT_RESUME_EN, resume=1 instead gives phase=5, halt=0 on the next edge.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase sequencing FSM for the 8-bit accumulator CPU.
// Decodes (phase, opcode, zero, halted) into the datapath strobes.
// Optional build macro CTRL_HALT_RESUME_EN adds a `resume` input that
// releases a halted CPU into phase 5, so the HLT completes as a no-op.
module cpu_controller (
    input  logic       clk,
    input  logic       rst,
`ifdef CTRL_HALT_RESUME_EN
    input  logic       resume,
`endif
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    localparam int unsigned OPC_W   = 3;
    localparam int unsigned PHASE_W = 3;

    localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_LDA = 3'b101;
    localparam logic [OPC_W-1:0] OP_STO = 3'b110;
    localparam logic [OPC_W-1:0] OP_JMP = 3'b111;

    typedef enum logic [PHASE_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    phase_e phase_q;
    logic   halted_q;

    logic is_hlt;
    logic is_skz;
    logic is_aluop;
    logic is_sto;
    logic is_jmp;

    // Opcode classification; any unmatched encoding decodes to no class.
    always_comb begin
        is_hlt   = 1'b0;
        is_skz   = 1'b0;
        is_aluop = 1'b0;
        is_sto   = 1'b0;
        is_jmp   = 1'b0;
        case (opcode)
            OP_HLT:                         is_hlt   = 1'b1;
            OP_SKZ:                         is_skz   = 1'b1;
            OP_ADD, OP_AND, OP_XOR, OP_LDA: is_aluop = 1'b1;
            OP_STO:                         is_sto   = 1'b1;
            OP_JMP:                         is_jmp   = 1'b1;
            default: ;
        endcase
    end

    // Phase counter and halted flag; HLT at OP_ADDR freezes the phase at 4.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else if (halted_q) begin
`ifdef CTRL_HALT_RESUME_EN
            if (resume) begin
                halted_q <= 1'b0;
                phase_q  <= PH_OP_FETCH;
            end
`endif
        end else if (phase_q == PH_OP_ADDR && is_hlt) begin
            halted_q <= 1'b1;
        end else begin
            phase_q <= phase_e'(phase_q + PHASE_W'(1));
        end
    end

    // Strobe decode; reset cycle forces reset values so no partial write escapes.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (rst) begin
            sel = 1'b1;
        end else if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                PH_OP_FETCH: begin
                    rd = is_aluop;
                end
                PH_ALU_OP: begin
                    rd     = is_aluop;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                PH_STORE: begin
                    rd     = is_aluop;
                    ld_ac  = is_aluop;
                    ld_pc  = is_jmp;
                    inc_pc = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

    assign phase = phase_q;

`ifndef SYNTHESIS
    // Memory read and write must never be requested together.
    rd_wr_exclusive: assert property (@(posedge clk) !(rd && wr));
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller.
// Output vector order: {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
`ifdef CTRL_HALT_RESUME_EN
    logic       resume = 1'b0;
`endif
    logic [2:0] opcode = 3'b000;
    logic       zero = 1'b0;
    logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
    logic [2:0] phase;
    logic [8:0] obs;

    int checks = 0;
    int errors = 0;

    assign obs = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt};

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
`ifdef CTRL_HALT_RESUME_EN
        .resume (resume),
`endif
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    // Fetch-phase expectations shared by every instruction (opcode-independent).
    localparam logic [8:0] E_P0  = 9'b100000000;
    localparam logic [8:0] E_P1  = 9'b110000000;
    localparam logic [8:0] E_P23 = 9'b110100000;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd0 || obs !== E_P0) begin
            errors++;
            $display("FAIL reset: phase=%0d outs=%b, expected phase=0 outs=%b", phase, obs, E_P0);
        end
        for (int i = 1; i <= 8; i++) begin
            opcode = 3'b010;
            @(posedge clk); #1;
            checks++;
            if (phase !== 3'(i % 8)) begin
                errors++;
                $display("FAIL reset_seq: phase=%0d expected=%0d", phase, i % 8);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [2:0] ops [4];
        logic [8:0] exp [8];
        ops = '{3'b010, 3'b011, 3'b100, 3'b101};
        exp = '{E_P0, E_P1, E_P23, E_P23,
                9'b000010000, 9'b010000000, 9'b010000000, 9'b010000100};
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 8; p++) begin
                opcode = (p < 4) ? ~ops[k] : ops[k];
                zero   = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (phase !== 3'(p) || obs !== exp[p]) begin
                    errors++;
                    $display("FAIL alu_op%0b p%0d: phase=%0d outs=%b expected outs=%b", ops[k], p, phase, obs, exp[p]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_sto();
        logic [8:0] exp [8];
        exp = '{E_P0, E_P1, E_P23, E_P23,
                9'b000010000, 9'b000000000, 9'b000000010, 9'b001000010};
        for (int p = 0; p < 8; p++) begin
            opcode = (p < 4) ? 3'b001 : 3'b110;
            zero   = 1'b1;
            #1;
            checks++;
            if (phase !== 3'(p) || obs !== exp[p]) begin
                errors++;
                $display("FAIL sto p%0d: phase=%0d outs=%b expected outs=%b", p, phase, obs, exp[p]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_skz();
        logic [8:0] exp [8];
        for (int zv = 1; zv >= 0; zv--) begin
            exp = '{E_P0, E_P1, E_P23, E_P23,
                    9'b000010000, 9'b000000000,
                    (zv == 1) ? 9'b000010000 : 9'b000000000, 9'b000000000};
            for (int p = 0; p < 8; p++) begin
                opcode = (p < 4) ? 3'b110 : 3'b001;
                // zero carries the opposite value everywhere except phase 6
                zero   = (p == 6) ? 1'(zv) : ~1'(zv);
                #1;
                checks++;
                if (phase !== 3'(p) || obs !== exp[p]) begin
                    errors++;
                    $display("FAIL skz z%0d p%0d: phase=%0d outs=%b expected outs=%b", zv, p, phase, obs, exp[p]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jmp();
        logic [8:0] exp [8];
        exp = '{E_P0, E_P1, E_P23, E_P23,
                9'b000010000, 9'b000000000, 9'b000001000, 9'b000011000};
        for (int p = 0; p < 8; p++) begin
            opcode = (p < 4) ? 3'b000 : 3'b111;
            zero   = 1'b1;
            #1;
            checks++;
            if (phase !== 3'(p) || obs !== exp[p]) begin
                errors++;
                $display("FAIL jmp p%0d: phase=%0d outs=%b expected outs=%b", p, phase, obs, exp[p]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 7; p++) begin
            opcode = 3'b110;
            @(posedge clk); #1;
        end
        #1;
        checks++;
        if (phase !== 3'd7 || obs !== 9'b001000010) begin
            errors++;
            $display("FAIL reset_mid_pre: phase=%0d outs=%b expected phase=7 outs=001000010", phase, obs);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== E_P0) begin
            errors++;
            $display("FAIL reset_mid_cycle: outs=%b expected=%b", obs, E_P0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd0 || obs !== E_P0) begin
            errors++;
            $display("FAIL reset_mid_post: phase=%0d outs=%b expected phase=0 outs=%b", phase, obs, E_P0);
        end
    endtask

    task automatic test_hlt();
        for (int p = 0; p < 4; p++) begin
            opcode = 3'b111;
            @(posedge clk); #1;
        end
        opcode = 3'b000;
        #1;
        checks++;
        if (phase !== 3'd4 || obs !== 9'b000010001) begin
            errors++;
            $display("FAIL hlt_entry: phase=%0d outs=%b expected phase=4 outs=000010001", phase, obs);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            opcode = 3'(k);
            zero   = 1'(k);
            #1;
            checks++;
            if (phase !== 3'd4 || obs !== 9'b000000001) begin
                errors++;
                $display("FAIL hlt_hold%0d: phase=%0d outs=%b expected phase=4 outs=000000001", k, phase, obs);
            end
        end
`ifdef CTRL_HALT_RESUME_EN
        opcode = 3'b000;
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd5 || halt !== 1'b0 || obs !== 9'b000000000) begin
            errors++;
            $display("FAIL hlt_resume: phase=%0d outs=%b expected phase=5 outs=000000000", phase, obs);
        end
        for (int p = 6; p <= 8; p++) begin
            @(posedge clk); #1;
            checks++;
            if (phase !== 3'(p % 8)) begin
                errors++;
                $display("FAIL hlt_resume_seq: phase=%0d expected=%0d", phase, p % 8);
            end
        end
`else
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== E_P0) begin
            errors++;
            $display("FAIL hlt_rst_cycle: outs=%b expected=%b", obs, E_P0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd0 || obs !== E_P0) begin
            errors++;
            $display("FAIL hlt_rst_exit: phase=%0d outs=%b expected phase=0 outs=%b", phase, obs, E_P0);
        end
`endif
    endtask

    // Instructions issued back to back after the halt exit, no gap between them.
    task automatic test_back_to_back();
        logic [2:0] ops [3];
        logic [8:0] e7  [3];
        ops = '{3'b110, 3'b010, 3'b111};
        e7  = '{9'b001000010, 9'b010000100, 9'b000011000};
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 8; p++) begin
                opcode = ops[k];
                #1;
                if (p == 7) begin
                    checks++;
                    if (phase !== 3'd7 || obs !== e7[k]) begin
                        errors++;
                        $display("FAIL b2b op%0b: phase=%0d outs=%b expected outs=%b", ops[k], phase, obs, e7[k]);
                    end
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_sto();
        test_skz();
        test_jmp();
        test_reset_mid();
        test_hlt();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
